// File: rtl/ternary_trit_serial_sched_if.sv
// Requester-side bundle of the shared trit ALU scheduler.
// The err signal exists only when TERN_INVALID_CHECK_EN is defined.
interface ternary_trit_serial_sched_if #(
  parameter int NREQ  = 4,
  parameter int TRITS = 8
);
  logic [NREQ-1:0]         req;
  logic [2*NREQ-1:0]       op_flat;
  logic [2*TRITS*NREQ-1:0] a_flat;
  logic [2*TRITS*NREQ-1:0] b_flat;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         done;
  logic [2*TRITS-1:0]      result;
  logic                    busy;
`ifdef TERN_INVALID_CHECK_EN
  logic                    err;

  modport master (output req, op_flat, a_flat, b_flat,
                  input gnt, done, result, busy, err);
  modport slave  (input req, op_flat, a_flat, b_flat,
                  output gnt, done, result, busy, err);
`else
  modport master (output req, op_flat, a_flat, b_flat,
                  input gnt, done, result, busy);
  modport slave  (input req, op_flat, a_flat, b_flat,
                  output gnt, done, result, busy);
`endif
endinterface

// File: rtl/ternary_trit_serial_sched.sv
// Round-robin scheduler sharing one trit-serial ternary ALU among NREQ requesters.
// Optional macro TERN_INVALID_CHECK_EN: abort on a 11 trit code and flag err.
module ternary_trit_serial_sched #(
  parameter int NREQ  = 4,
  parameter int TRITS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  ternary_trit_serial_sched_if.slave     bus
);
  localparam int W  = 2 * TRITS;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TRITS > 1) ? $clog2(TRITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t         r_state, w_state_next;
  logic [PW-1:0]  r_g, r_prio, w_pick, w_prio_next;
  logic           w_found;
  logic [W-1:0]   r_a_sr, r_b_sr, r_res_sr, r_result, w_res_shift;
  logic [1:0]     r_op, w_alu;
  logic [CW-1:0]  r_cnt;
  logic           w_last;
  logic           w_inv;
`ifdef TERN_INVALID_CHECK_EN
  logic           r_err;
`endif

  // Gate-level trit operators on the {t1,t0} encoding (0=00, 1=01, 2=10).
  function automatic logic [1:0] trit_alu(input logic [1:0] op, input logic [1:0] a,
                                          input logic [1:0] b);
    logic o1, o0;
    o1 = 1'b0;
    o0 = 1'b0;
    case (op)
      2'b00: begin
        o1 = a[1] | b[1];
        o0 = ~o1 & (a[0] | b[0]);
      end
      2'b01: begin
        o1 = a[1] & b[1];
        o0 = ~o1 & (a[0] | a[1]) & (b[0] | b[1]);
      end
      2'b10: begin
        o1 = a[1] & b[1];
        o0 = ~o1 & (a[0] | a[1] | b[0] | b[1]);
      end
      default: begin
        o1 = (a[1] & (b[1] | b[0])) | (b[1] & a[0]);
        o0 = (a[0] & b[0]) | (a[1] & ~b[0] & ~b[1]) | (b[1] & ~a[0] & ~a[1]);
      end
    endcase
    return {o1, o0};
  endfunction

  assign w_alu  = trit_alu(r_op, r_a_sr[1:0], r_b_sr[1:0]);
  assign w_last = (r_cnt == CW'(TRITS - 1));
  assign w_prio_next = (r_g == PW'(NREQ - 1)) ? '0 : r_g + 1'b1;

`ifdef TERN_INVALID_CHECK_EN
  assign w_inv = (r_a_sr[1:0] == 2'b11) || (r_b_sr[1:0] == 2'b11);
`else
  assign w_inv = 1'b0;
`endif

  // New trits enter at the top so trit 0 lands at the LSB after TRITS shifts.
  generate
    if (TRITS == 1) begin : g_one
      assign w_res_shift = w_alu;
    end else begin : g_multi
      assign w_res_shift = {w_alu, r_res_sr[W-1:2]};
    end
  endgenerate

  // First pending requester at or after the priority pointer, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(r_prio) + i) % NREQ;
      if (!w_found && bus.req[PW'(idx)]) begin
        w_found = 1'b1;
        w_pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_RUN;
      S_RUN:   if (w_last || w_inv) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_g      <= '0;
      r_prio   <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
`ifdef TERN_INVALID_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: if (w_found) r_g <= w_pick;
        S_LOAD: begin
          r_a_sr   <= bus.a_flat[W*int'(r_g) +: W];
          r_b_sr   <= bus.b_flat[W*int'(r_g) +: W];
          r_op     <= bus.op_flat[2*int'(r_g) +: 2];
          r_res_sr <= '0;
          r_cnt    <= '0;
        end
        S_RUN: begin
          r_a_sr   <= r_a_sr >> 2;
          r_b_sr   <= r_b_sr >> 2;
          r_res_sr <= w_res_shift;
          r_cnt    <= r_cnt + 1'b1;
          // An aborted word reports all zeros rather than a partial result.
          if (w_inv) begin
            r_result <= '0;
`ifdef TERN_INVALID_CHECK_EN
            r_err    <= 1'b1;
`endif
          end else if (w_last) begin
            r_result <= w_res_shift;
          end
        end
        S_DONE: begin
          r_prio <= w_prio_next;
`ifdef TERN_INVALID_CHECK_EN
          r_err  <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.gnt    = bus.busy ? (NREQ'(1) << r_g) : '0;
  assign bus.done   = (r_state == S_DONE) ? (NREQ'(1) << r_g) : '0;
  assign bus.result = r_result;
`ifdef TERN_INVALID_CHECK_EN
  assign bus.err    = r_err;
`endif
endmodule
